// File: rtl/dca_matrix_lsu_local_responder.sv
// Local row-buffer responder for the matrix-LSU instruction/row-stream interface.
// LOAD streams buffer rows out, STORE captures rows in; one instruction in flight at a time.
module dca_matrix_lsu_local_responder #(
   parameter int BW_ROW  = 128,
   parameter int DEPTH   = 64,
   parameter int BW_INST = 32
) (
   input  logic               clk,
   input  logic               rstnn,
   input  logic               sinst_wvalid,
   input  logic [BW_INST-1:0] sinst_wdata,
   output logic               sinst_wready,
   output logic               sinst_decode_finish,
   output logic               sinst_execute_finish,
   output logic               sinst_busy,
   output logic               sload_tensor_row_wvalid,
   output logic               sload_tensor_row_wlast,
   output logic [BW_ROW-1:0]  sload_tensor_row_wdata,
   input  logic               sload_tensor_row_wready,
   output logic               sstore_tensor_row_rvalid,
   output logic               sstore_tensor_row_rlast,
   input  logic               sstore_tensor_row_rready,
   input  logic [BW_ROW-1:0]  sstore_tensor_row_rdata
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0] OP_LOAD  = 2'd1;
   localparam logic [1:0] OP_STORE = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_LOAD,
      S_STORE,
      S_FINISH
   } state_t;

   state_t            r_state;
   logic [PW-1:0]     r_ptr;
   logic [8:0]        r_remaining;
   logic [1:0]        r_opcode;
   logic              r_wready;
   logic              r_decode_finish;
   logic              r_execute_finish;
   logic              r_busy;
   logic              r_load_valid;
   logic              r_store_valid;
   logic              r_last;
   logic [BW_ROW-1:0] r_mem [DEPTH];

   logic              w_accept;
   logic [PW-1:0]     w_start;
   logic [8:0]        w_count;
   logic              w_load_beat;
   logic              w_store_beat;
   logic              w_mem_write;
   logic              w_last_beat;
   logic              w_unused_inst;

   assign w_accept     = r_wready & sinst_wvalid;
   assign w_start      = sinst_wdata[2 +: PW];
   assign w_count      = {1'b0, sinst_wdata[17:10]} + 9'd1;
   assign w_load_beat  = r_load_valid & sload_tensor_row_wready;
   assign w_store_beat = r_store_valid & sstore_tensor_row_rready;
   // A reset edge must never commit a pending store beat.
   assign w_mem_write  = w_store_beat & ~rstnn;
   assign w_last_beat  = (r_remaining == 9'd1);
   assign w_unused_inst = ^sinst_wdata;

   always_ff @(posedge clk) begin
      if (rstnn) begin
         r_state          <= S_IDLE;
         r_ptr            <= '0;
         r_remaining      <= '0;
         r_opcode         <= '0;
         r_wready         <= 1'b1;
         r_decode_finish  <= 1'b0;
         r_execute_finish <= 1'b0;
         r_busy           <= 1'b0;
         r_load_valid     <= 1'b0;
         r_store_valid    <= 1'b0;
         r_last           <= 1'b0;
      end else begin
         r_decode_finish  <= 1'b0;
         r_execute_finish <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ptr           <= w_start;
                  r_remaining     <= w_count;
                  r_opcode        <= sinst_wdata[1:0];
                  r_wready        <= 1'b0;
                  r_busy          <= 1'b1;
                  r_decode_finish <= 1'b1;
                  r_state         <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (r_opcode == OP_LOAD) begin
                  r_load_valid <= 1'b1;
                  r_last       <= w_last_beat;
                  r_state      <= S_LOAD;
               end else if (r_opcode == OP_STORE) begin
                  r_store_valid <= 1'b1;
                  r_last        <= w_last_beat;
                  r_state       <= S_STORE;
               end else begin
                  r_execute_finish <= 1'b1;
                  r_last           <= 1'b0;
                  r_state          <= S_FINISH;
               end
            end
            S_LOAD: begin
               if (w_load_beat) begin
                  r_ptr       <= r_ptr + PW'(1);
                  r_remaining <= r_remaining - 9'd1;
                  if (w_last_beat) begin
                     r_load_valid     <= 1'b0;
                     r_last           <= 1'b0;
                     r_execute_finish <= 1'b1;
                     r_state          <= S_FINISH;
                  end else begin
                     r_last <= (r_remaining == 9'd2);
                  end
               end
            end
            S_STORE: begin
               if (w_store_beat) begin
                  r_ptr       <= r_ptr + PW'(1);
                  r_remaining <= r_remaining - 9'd1;
                  if (w_last_beat) begin
                     r_store_valid    <= 1'b0;
                     r_last           <= 1'b0;
                     r_execute_finish <= 1'b1;
                     r_state          <= S_FINISH;
                  end else begin
                     r_last <= (r_remaining == 9'd2);
                  end
               end
            end
            S_FINISH: begin
               r_wready <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_wready      <= 1'b1;
               r_busy        <= 1'b0;
               r_load_valid  <= 1'b0;
               r_store_valid <= 1'b0;
               r_last        <= 1'b0;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   // Row storage is deliberately unreset so contents survive a reset.
   always_ff @(posedge clk) begin
      if (w_mem_write) begin
         r_mem[r_ptr] <= sstore_tensor_row_rdata;
      end
   end

   assign sinst_wready             = r_wready;
   assign sinst_decode_finish      = r_decode_finish;
   assign sinst_execute_finish     = r_execute_finish;
   assign sinst_busy               = r_busy;
   assign sload_tensor_row_wvalid  = r_load_valid;
   assign sload_tensor_row_wlast   = r_last & r_load_valid;
   assign sload_tensor_row_wdata   = r_load_valid ? r_mem[r_ptr] : '0;
   assign sstore_tensor_row_rvalid = r_store_valid;
   assign sstore_tensor_row_rlast  = r_last & r_store_valid;

endmodule

// File: tb/tb_dca_matrix_lsu_local_responder.sv
// Self-checking bench for dca_matrix_lsu_local_responder: randomized instructions
// scored against an array model of the row buffer.
module tb_dca_matrix_lsu_local_responder;

   localparam int BW_ROW  = 128;
   localparam int DEPTH   = 64;
   localparam int BW_INST = 32;

   logic               clk = 1'b0;
   logic               rstnn = 1'b1;
   logic               sinst_wvalid = 1'b0;
   logic [BW_INST-1:0] sinst_wdata = '0;
   logic               sinst_wready;
   logic               sinst_decode_finish;
   logic               sinst_execute_finish;
   logic               sinst_busy;
   logic               sload_tensor_row_wvalid;
   logic               sload_tensor_row_wlast;
   logic [BW_ROW-1:0]  sload_tensor_row_wdata;
   logic               sload_tensor_row_wready = 1'b0;
   logic               sstore_tensor_row_rvalid;
   logic               sstore_tensor_row_rlast;
   logic               sstore_tensor_row_rready = 1'b0;
   logic [BW_ROW-1:0]  sstore_tensor_row_rdata = '0;

   always #5 clk = ~clk;

   dca_matrix_lsu_local_responder #(
      .BW_ROW (BW_ROW),
      .DEPTH  (DEPTH),
      .BW_INST(BW_INST)
   ) dut (
      .clk                     (clk),
      .rstnn                   (rstnn),
      .sinst_wvalid            (sinst_wvalid),
      .sinst_wdata             (sinst_wdata),
      .sinst_wready            (sinst_wready),
      .sinst_decode_finish     (sinst_decode_finish),
      .sinst_execute_finish    (sinst_execute_finish),
      .sinst_busy              (sinst_busy),
      .sload_tensor_row_wvalid (sload_tensor_row_wvalid),
      .sload_tensor_row_wlast  (sload_tensor_row_wlast),
      .sload_tensor_row_wdata  (sload_tensor_row_wdata),
      .sload_tensor_row_wready (sload_tensor_row_wready),
      .sstore_tensor_row_rvalid(sstore_tensor_row_rvalid),
      .sstore_tensor_row_rlast (sstore_tensor_row_rlast),
      .sstore_tensor_row_rready(sstore_tensor_row_rready),
      .sstore_tensor_row_rdata (sstore_tensor_row_rdata)
   );

   int nCompared = 0;
   int nFailed   = 0;

   // Reference model: what each buffer row should hold.
   logic [BW_ROW-1:0] modelMem [DEPTH];

   logic [BW_ROW-1:0] obsLoad[$];
   logic [BW_ROW-1:0] storeQ[$];
   bit                readyPat[$];
   int                readyMode;
   int                tDecode, tFirst, tExec, nStore, nProto;
   bit                timedOut;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BW_INST-1:0] makeInst(input int op, input int start, input int cntm1);
      logic [13:0] junk;
      logic [7:0]  s;
      logic [7:0]  c;
      logic [1:0]  o;
      junk = 14'($urandom);
      s    = 8'(start);
      c    = 8'(cntm1);
      o    = 2'(op);
      return {junk, c, s, o};
   endfunction

   // Presents one instruction for a single accepting edge; returns in the cycle after acceptance.
   task automatic issueInst(input int op, input int start, input int cntm1, output bit ok);
      int w = 0;
      while (!sinst_wready && w < 50) begin
         step();
         w++;
      end
      ok = sinst_wready;
      sinst_wdata  = makeInst(op, start, cntm1);
      sinst_wvalid = 1'b1;
      step();
      sinst_wvalid = 1'b0;
   endtask

   // Runs one instruction to completion, recording what the DUT did and updating the model on store beats.
   task automatic doInst(input int op, input int start, input int cntm1);
      int cnt = cntm1 + 1;
      int t = 1;
      int vc = 0;
      int nl = 0;
      int ns = 0;
      bit rdy;
      bit ok;
      bit prevStall = 0;
      logic [BW_ROW-1:0] prevData = '0;
      logic prevLast = 1'b0;
      logic [BW_ROW-1:0] d;
      obsLoad.delete();
      tDecode = -1; tFirst = -1; tExec = -1; nStore = 0; nProto = 0; timedOut = 0;
      issueInst(op, start, cntm1, ok);
      if (!ok) timedOut = 1;
      forever begin
         if (t > 4 * cnt + 600) begin
            timedOut = 1;
            break;
         end
         if (!sinst_busy || sinst_wready) nProto++;
         if (sinst_decode_finish) begin
            if (tDecode < 0) tDecode = t;
            else nProto++;
         end
         case (readyMode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(0, 2) != 0);
            default: rdy = (vc < readyPat.size()) ? readyPat[vc] : 1'b1;
         endcase
         if ((sload_tensor_row_wvalid || sstore_tensor_row_rvalid) && tFirst < 0) tFirst = t;
         if (sload_tensor_row_wvalid && op != 1) nProto++;
         if (sstore_tensor_row_rvalid && op != 2) nProto++;
         if (prevStall && (!sload_tensor_row_wvalid || sload_tensor_row_wdata !== prevData ||
                           sload_tensor_row_wlast !== prevLast)) nProto++;
         prevStall = 0;
         if (sload_tensor_row_wvalid) begin
            if (sload_tensor_row_wlast !== (nl == cnt - 1)) nProto++;
            vc++;
            if (rdy) begin
               obsLoad.push_back(sload_tensor_row_wdata);
               nl++;
            end else begin
               prevStall = 1;
               prevData  = sload_tensor_row_wdata;
               prevLast  = sload_tensor_row_wlast;
            end
         end
         d = {$urandom(), $urandom(), $urandom(), $urandom()};
         if (sstore_tensor_row_rvalid) begin
            if (sstore_tensor_row_rlast !== (ns == cnt - 1)) nProto++;
            vc++;
            if (rdy) begin
               if (storeQ.size() > 0) d = storeQ.pop_front();
               modelMem[(start + ns) % DEPTH] = d;
               ns++;
            end
         end
         sload_tensor_row_wready  = rdy;
         sstore_tensor_row_rready = rdy;
         sstore_tensor_row_rdata  = d;
         if (sinst_execute_finish) begin
            tExec = t;
            break;
         end
         step();
         t++;
      end
      nStore = ns;
      sload_tensor_row_wready  = 1'b0;
      sstore_tensor_row_rready = 1'b0;
   endtask

   task automatic test_reset();
      rstnn = 1'b1;
      repeat (3) step();
      rstnn = 1'b0;
      step();
      nCompared++;
      if (sinst_wready !== 1'b1) begin
         nFailed++;
         $display("[TB] FAIL reset_wready: got %b want 1", sinst_wready);
      end
      nCompared++;
      if ({sinst_busy, sinst_decode_finish, sinst_execute_finish, sload_tensor_row_wvalid,
           sload_tensor_row_wlast, sstore_tensor_row_rvalid, sstore_tensor_row_rlast} !== 7'b0) begin
         nFailed++;
         $display("[TB] FAIL reset_outputs: got %b%b%b%b%b%b%b want 0000000", sinst_busy, sinst_decode_finish,
                  sinst_execute_finish, sload_tensor_row_wvalid, sload_tensor_row_wlast,
                  sstore_tensor_row_rvalid, sstore_tensor_row_rlast);
      end
      nCompared++;
      if (sload_tensor_row_wdata !== '0) begin
         nFailed++;
         $display("[TB] FAIL reset_wdata: got %h want 0", sload_tensor_row_wdata);
      end
   endtask

   task automatic test_store_load();
      logic [BW_ROW-1:0] e;
      readyMode = 0;
      storeQ.delete();
      for (int k = 0; k < 4; k++) storeQ.push_back(BW_ROW'(8'hA0 + k));
      doInst(2, 2, 3);
      nCompared++;
      if (timedOut || tDecode != 1 || tFirst != 2 || tExec != 6) begin
         nFailed++;
         $display("[TB] FAIL store_timing: got to=%0d dec=%0d first=%0d exec=%0d want 0/1/2/6", timedOut, tDecode, tFirst, tExec);
      end
      nCompared++;
      if (nStore != 4 || nProto != 0) begin
         nFailed++;
         $display("[TB] FAIL store_beats: got beats=%0d proto=%0d want 4/0", nStore, nProto);
      end
      doInst(1, 2, 3);
      nCompared++;
      if (timedOut || tDecode != 1 || tFirst != 2 || tExec != 6 || nProto != 0) begin
         nFailed++;
         $display("[TB] FAIL load_timing: got to=%0d dec=%0d first=%0d exec=%0d proto=%0d want 0/1/2/6/0", timedOut, tDecode, tFirst, tExec, nProto);
      end
      nCompared++;
      if (obsLoad.size() != 4) begin
         nFailed++;
         $display("[TB] FAIL load_count: got %0d want 4", obsLoad.size());
      end
      for (int k = 0; k < 4 && k < obsLoad.size(); k++) begin
         e = BW_ROW'(8'hA0 + k);
         nCompared++;
         if (obsLoad[k] !== e) begin
            nFailed++;
            $display("[TB] FAIL load_data[%0d]: got %h want %h", k, obsLoad[k], e);
         end
      end
   endtask

   task automatic test_load_backpressure();
      bit p [7];
      logic [BW_ROW-1:0] e;
      p = '{1, 0, 0, 1, 0, 1, 1};
      readyPat.delete();
      foreach (p[i]) readyPat.push_back(p[i]);
      readyMode = 2;
      doInst(1, 2, 3);
      readyMode = 0;
      nCompared++;
      if (timedOut || tFirst != 2 || tExec != 9) begin
         nFailed++;
         $display("[TB] FAIL bp_timing: got to=%0d first=%0d exec=%0d want 0/2/9", timedOut, tFirst, tExec);
      end
      nCompared++;
      if (nProto != 0) begin
         nFailed++;
         $display("[TB] FAIL bp_stability: got %0d protocol errors want 0", nProto);
      end
      nCompared++;
      if (obsLoad.size() != 4) begin
         nFailed++;
         $display("[TB] FAIL bp_count: got %0d want 4", obsLoad.size());
      end
      for (int k = 0; k < 4 && k < obsLoad.size(); k++) begin
         e = BW_ROW'(8'hA0 + k);
         nCompared++;
         if (obsLoad[k] !== e) begin
            nFailed++;
            $display("[TB] FAIL bp_data[%0d]: got %h want %h", k, obsLoad[k], e);
         end
      end
   endtask

   task automatic test_wrap();
      readyMode = 0;
      storeQ.delete();
      storeQ.push_back(BW_ROW'(8'h11));
      storeQ.push_back(BW_ROW'(8'h22));
      storeQ.push_back(BW_ROW'(8'h33));
      doInst(2, 62, 2);
      nCompared++;
      if (timedOut || nStore != 3 || nProto != 0) begin
         nFailed++;
         $display("[TB] FAIL wrap_store: got to=%0d beats=%0d proto=%0d want 0/3/0", timedOut, nStore, nProto);
      end
      doInst(1, 63, 1);
      nCompared++;
      if (obsLoad.size() != 2 || obsLoad[0] !== BW_ROW'(8'h22) || obsLoad[1] !== BW_ROW'(8'h33)) begin
         nFailed++;
         $display("[TB] FAIL wrap_load: got n=%0d first=%h want 2 rows 22,33", obsLoad.size(),
                  (obsLoad.size() > 0) ? obsLoad[0] : '0);
      end
      doInst(1, 0, 0);
      nCompared++;
      if (obsLoad.size() != 1 || obsLoad[0] !== BW_ROW'(8'h33)) begin
         nFailed++;
         $display("[TB] FAIL wrap_row0: got n=%0d data=%h want 33", obsLoad.size(), (obsLoad.size() > 0) ? obsLoad[0] : '0);
      end
      doInst(1, 62 + 64, 0);
      nCompared++;
      if (obsLoad.size() != 1 || obsLoad[0] !== BW_ROW'(8'h11)) begin
         nFailed++;
         $display("[TB] FAIL start_high_bits: got n=%0d data=%h want 11", obsLoad.size(), (obsLoad.size() > 0) ? obsLoad[0] : '0);
      end
   endtask

   task automatic test_nop();
      logic [BW_ROW-1:0] e;
      readyMode = 0;
      storeQ.delete();
      for (int op = 0; op < 4; op += 3) begin
         doInst(op, 2, 3);
         nCompared++;
         if (timedOut || tDecode != 1 || tExec != 2 || nProto != 0 || obsLoad.size() != 0 || nStore != 0) begin
            nFailed++;
            $display("[TB] FAIL nop_op%0d: got to=%0d dec=%0d exec=%0d proto=%0d loads=%0d stores=%0d want 0/1/2/0/0/0",
                     op, timedOut, tDecode, tExec, nProto, obsLoad.size(), nStore);
         end
      end
      doInst(1, 2, 3);
      for (int k = 0; k < 4; k++) begin
         e = BW_ROW'(8'hA0 + k);
         nCompared++;
         if (k >= obsLoad.size() || obsLoad[k] !== e) begin
            nFailed++;
            $display("[TB] FAIL nop_unchanged[%0d]: got %h want %h", k, (k < obsLoad.size()) ? obsLoad[k] : '0, e);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      int seenExec;
      logic [BW_ROW-1:0] d0, d1, junk;
      readyMode = 1;
      storeQ.delete();
      doInst(2, 0, 63);
      nCompared++;
      if (timedOut || nStore != 64 || nProto != 0) begin
         nFailed++;
         $display("[TB] FAIL fill_store: got to=%0d beats=%0d proto=%0d want 0/64/0", timedOut, nStore, nProto);
      end
      readyMode = 0;
      issueInst(1, 2, 7, ok);
      sload_tensor_row_wready = 1'b1;
      step();
      nCompared++;
      if (sload_tensor_row_wvalid !== 1'b1 || sload_tensor_row_wdata !== modelMem[2]) begin
         nFailed++;
         $display("[TB] FAIL rst_load_beat0: got v=%b d=%h want 1/%h", sload_tensor_row_wvalid, sload_tensor_row_wdata, modelMem[2]);
      end
      step();
      nCompared++;
      if (sload_tensor_row_wdata !== modelMem[3]) begin
         nFailed++;
         $display("[TB] FAIL rst_load_beat1: got %h want %h", sload_tensor_row_wdata, modelMem[3]);
      end
      step();
      rstnn = 1'b1;
      step();
      nCompared++;
      if (sload_tensor_row_wvalid !== 1'b0 || sinst_busy !== 1'b0 || sinst_execute_finish !== 1'b0 || sinst_wready !== 1'b1) begin
         nFailed++;
         $display("[TB] FAIL rst_load_abort: got v=%b busy=%b exec=%b wready=%b want 0/0/0/1",
                  sload_tensor_row_wvalid, sinst_busy, sinst_execute_finish, sinst_wready);
      end
      rstnn = 1'b0;
      sload_tensor_row_wready = 1'b0;
      seenExec = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (sinst_execute_finish || sload_tensor_row_wvalid || !sinst_wready) seenExec++;
      end
      nCompared++;
      if (seenExec != 0) begin
         nFailed++;
         $display("[TB] FAIL rst_load_quiet: got %0d active cycles want 0", seenExec);
      end
      issueInst(2, 10, 3, ok);
      d0 = {$urandom(), $urandom(), $urandom(), $urandom()};
      d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      junk = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
      nCompared++;
      if (sstore_tensor_row_rvalid !== 1'b1) begin
         nFailed++;
         $display("[TB] FAIL rst_store_rvalid: got %b want 1", sstore_tensor_row_rvalid);
      end
      sstore_tensor_row_rready = 1'b1;
      sstore_tensor_row_rdata  = d0;
      modelMem[10] = d0;
      step();
      sstore_tensor_row_rdata = d1;
      modelMem[11] = d1;
      step();
      sstore_tensor_row_rdata = junk;
      rstnn = 1'b1;
      step();
      rstnn = 1'b0;
      sstore_tensor_row_rready = 1'b0;
      step();
      readyMode = 1;
      doInst(1, 10, 2);
      for (int k = 0; k < 3; k++) begin
         nCompared++;
         if (k >= obsLoad.size() || obsLoad[k] !== modelMem[10 + k]) begin
            nFailed++;
            $display("[TB] FAIL rst_store_row%0d: got %h want %h", 10 + k, (k < obsLoad.size()) ? obsLoad[k] : '0, modelMem[10 + k]);
         end
      end
      doInst(1, 2, 7);
      for (int k = 0; k < 8; k++) begin
         nCompared++;
         if (k >= obsLoad.size() || obsLoad[k] !== modelMem[2 + k]) begin
            nFailed++;
            $display("[TB] FAIL rst_reload[%0d]: got %h want %h", k, (k < obsLoad.size()) ? obsLoad[k] : '0, modelMem[2 + k]);
         end
      end
      readyMode = 0;
   endtask

   task automatic test_back_to_back();
      int w = 0;
      bit low;
      while (!sinst_wready && w < 50) begin
         step();
         w++;
      end
      sinst_wdata  = makeInst(0, 0, 0);
      sinst_wvalid = 1'b1;
      step();
      sinst_wdata = makeInst(1, 2, 0);
      low = (sinst_wready === 1'b0);
      step();
      low = low && (sinst_wready === 1'b0);
      nCompared++;
      if (!low || sinst_execute_finish !== 1'b1) begin
         nFailed++;
         $display("[TB] FAIL b2b_first: got wready_low=%0d exec=%b want 1/1", low, sinst_execute_finish);
      end
      step();
      nCompared++;
      if (sinst_wready !== 1'b1) begin
         nFailed++;
         $display("[TB] FAIL b2b_idle_wready: got %b want 1", sinst_wready);
      end
      step();
      sinst_wvalid = 1'b0;
      sload_tensor_row_wready = 1'b1;
      nCompared++;
      if (sinst_decode_finish !== 1'b1 || sinst_wready !== 1'b0) begin
         nFailed++;
         $display("[TB] FAIL b2b_second_decode: got dec=%b wready=%b want 1/0", sinst_decode_finish, sinst_wready);
      end
      step();
      nCompared++;
      if (sload_tensor_row_wvalid !== 1'b1 || sload_tensor_row_wlast !== 1'b1 || sload_tensor_row_wdata !== modelMem[2]) begin
         nFailed++;
         $display("[TB] FAIL b2b_second_row: got v=%b l=%b d=%h want 1/1/%h", sload_tensor_row_wvalid,
                  sload_tensor_row_wlast, sload_tensor_row_wdata, modelMem[2]);
      end
      step();
      nCompared++;
      if (sinst_execute_finish !== 1'b1) begin
         nFailed++;
         $display("[TB] FAIL b2b_second_exec: got %b want 1", sinst_execute_finish);
      end
      sload_tensor_row_wready = 1'b0;
      step();
   endtask

   task automatic test_random();
      int op, start, cntm1, cnt;
      logic [BW_ROW-1:0] expQ[$];
      for (int it = 0; it < 40; it++) begin
         op    = $urandom_range(0, 3);
         start = $urandom_range(0, 255);
         cntm1 = ($urandom_range(0, 7) == 0) ? $urandom_range(64, 140) : $urandom_range(0, 15);
         cnt   = cntm1 + 1;
         readyMode = $urandom_range(0, 1);
         storeQ.delete();
         expQ.delete();
         for (int k = 0; k < cnt; k++) expQ.push_back(modelMem[(start + k) % DEPTH]);
         doInst(op, start, cntm1);
         nCompared++;
         if (timedOut || tDecode != 1 || nProto != 0) begin
            nFailed++;
            $display("[TB] FAIL rand%0d_proto: got to=%0d dec=%0d proto=%0d want 0/1/0 (op=%0d start=%0d cnt=%0d)",
                     it, timedOut, tDecode, nProto, op, start, cnt);
         end
         nCompared++;
         if ((op == 1 && obsLoad.size() != cnt) || (op == 2 && nStore != cnt) ||
             (op != 1 && op != 2 && tExec != 2) ||
             ((op == 1 || op == 2) && readyMode == 0 && tExec != 2 + cnt)) begin
            nFailed++;
            $display("[TB] FAIL rand%0d_beats: got loads=%0d stores=%0d exec=%0d (op=%0d cnt=%0d mode=%0d)",
                     it, obsLoad.size(), nStore, tExec, op, cnt, readyMode);
         end
         if (op == 1) begin
            for (int k = 0; k < obsLoad.size() && k < cnt; k++) begin
               nCompared++;
               if (obsLoad[k] !== expQ[k]) begin
                  nFailed++;
                  $display("[TB] FAIL rand%0d_data[%0d]: got %h want %h", it, k, obsLoad[k], expQ[k]);
               end
            end
         end
      end
      readyMode = 0;
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      readyMode = 0;
      test_reset();
      test_store_load();
      test_load_backpressure();
      test_wrap();
      test_nop();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule
